// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: IF/ID/EX/MEM/WB control FSM for the RV32I-subset multicycle core.
// Optional ILLEGAL_TRAP_EN: unsupported opcodes halt the core and set a sticky illegal flag.
module multicycle_ctrl #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          instr,
    input  logic                 Zero,
    input  logic                 dReady,
    output logic                 PCSrc,
    output logic                 ALUSrc,
    output logic                 RegWrite,
    output logic                 MemToReg,
    output logic [3:0]           ALUCtrl,
    output logic                 loadPC,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic [CNT_WIDTH-1:0] retired,
    output logic                 illegal
);
    typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT} state_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_SLL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   retired_q, retired_d;
    logic                   is_r, is_i, is_lw, is_sw, is_beq, in_exe;
    logic [3:0]             f3_op, alu_op;
    logic                   unused_bits;

    assign unused_bits = ^{instr[31], instr[29:15], instr[11:7]};

    assign is_r   = instr[6:0] == OP_R;
    assign is_i   = instr[6:0] == OP_I;
    assign is_lw  = instr[6:0] == OP_LW;
    assign is_sw  = instr[6:0] == OP_SW;
    assign is_beq = instr[6:0] == OP_BEQ;

    // instr[30] selects SUB only for R-type; for I-type it is immediate bit 10
    always_comb begin
        f3_op = ALU_ADD;
        case (instr[14:12])
            3'b000:  f3_op = (is_r && instr[30]) ? ALU_SUB : ALU_ADD;
            3'b001:  f3_op = ALU_SLL;
            3'b010:  f3_op = ALU_SLT;
            3'b100:  f3_op = ALU_XOR;
            3'b101:  f3_op = instr[30] ? ALU_SRA : ALU_SRL;
            3'b110:  f3_op = ALU_OR;
            3'b111:  f3_op = ALU_AND;
            default: f3_op = ALU_ADD;
        endcase
    end

    assign alu_op = is_beq ? ALU_SUB : (is_r || is_i) ? f3_op : ALU_ADD;
    assign in_exe = state_q == S_EX || state_q == S_MEM || state_q == S_WB;

    assign ALUCtrl  = in_exe ? alu_op : ALU_ADD;
    assign ALUSrc   = in_exe && (is_i || is_lw || is_sw);
    assign MemRead  = state_q == S_MEM && is_lw;
    assign MemWrite = state_q == S_MEM && is_sw;
    assign loadPC   = state_q == S_WB;
    assign RegWrite = state_q == S_WB && (is_r || is_i || is_lw);
    assign MemToReg = state_q == S_WB && is_lw;
    assign PCSrc    = state_q == S_WB && is_beq && Zero;
    assign retired  = retired_q;

    always_comb begin
        state_d   = state_q;
        retired_d = retired_q;
        case (state_q)
            S_IF:    state_d = S_ID;
`ifdef ILLEGAL_TRAP_EN
            S_ID:    state_d = (is_r || is_i || is_lw || is_sw || is_beq) ? S_EX : S_HALT;
`else
            S_ID:    state_d = S_EX;
`endif
            S_EX:    state_d = (is_lw || is_sw) ? S_MEM : S_WB;
            S_MEM:   state_d = dReady ? S_WB : S_MEM;
            S_WB: begin
                state_d   = S_IF;
                retired_d = retired_q + 1'b1;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IF;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IF;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;

    assign illegal_d = illegal_q || state_d == S_HALT;
    assign illegal   = illegal_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) illegal_q <= 1'b0;
        else     illegal_q <= illegal_d;
    end
`else
    assign illegal = 1'b0;
`endif
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed-vector bench for multicycle_ctrl; checks every strobe every cycle.
module tb_multicycle_ctrl;
    logic        clk = 1'b0;
    logic        rst, Zero, dReady;
    logic [31:0] instr;
    logic        PCSrc, ALUSrc, RegWrite, MemToReg, loadPC, MemRead, MemWrite, illegal;
    logic [3:0]  ALUCtrl;
    logic [31:0] retired;
    logic [10:0] outs;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] exp_ret = 0;

    localparam logic [10:0] IDLE = 11'b0000000_0010;

    multicycle_ctrl #(.CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .instr(instr), .Zero(Zero), .dReady(dReady),
        .PCSrc(PCSrc), .ALUSrc(ALUSrc), .RegWrite(RegWrite), .MemToReg(MemToReg),
        .ALUCtrl(ALUCtrl), .loadPC(loadPC), .MemRead(MemRead), .MemWrite(MemWrite),
        .retired(retired), .illegal(illegal)
    );

    always #5 clk = ~clk;

    assign outs = {PCSrc, ALUSrc, RegWrite, MemToReg, loadPC, MemRead, MemWrite, ALUCtrl};

    function automatic logic [10:0] mk(input logic pcs, als, rw, m2r, lpc, mr, mw, input logic [3:0] alu);
        return {pcs, als, rw, m2r, lpc, mr, mw, alu};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic [10:0] exp);
        chk(tag, {21'd0, outs}, {21'd0, exp});
        @(negedge clk);
    endtask

    // R/I-type ALU instruction: IF, ID, EX, WB with RegWrite+loadPC in WB
    task automatic run_alu(input string tag, input logic [31:0] ins, input logic imm, input logic [3:0] alu);
        instr = ins;
        step({tag, "_if"}, IDLE);
        step({tag, "_id"}, IDLE);
        step({tag, "_ex"}, mk(0, imm, 0, 0, 0, 0, 0, alu));
        step({tag, "_wb"}, mk(0, imm, 1, 0, 1, 0, 0, alu));
        exp_ret++;
        chk({tag, "_ret"}, retired, exp_ret);
    endtask

    initial begin
        rst = 1'b1; instr = 32'h0; Zero = 1'b0; dReady = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outs", {21'd0, outs}, {21'd0, IDLE});
        chk("reset_ret", retired, 32'd0);
        chk("reset_illegal", {31'd0, illegal}, 32'd0);
        rst = 1'b0;

        run_alu("add", 32'h002081B3, 1'b0, 4'b0010);

        // lw with dReady low for three MEM cycles
        instr = 32'h0000A283;
        step("lw_if", IDLE);
        step("lw_id", IDLE);
        step("lw_ex", mk(0, 1, 0, 0, 0, 0, 0, 4'b0010));
        for (int i = 0; i < 4; i++) begin
            dReady = (i == 3);
            step("lw_mem", mk(0, 1, 0, 0, 0, 1, 0, 4'b0010));
        end
        dReady = 1'b0;
        step("lw_wb", mk(0, 1, 1, 1, 1, 0, 0, 4'b0010));
        exp_ret++;
        chk("lw_ret", retired, exp_ret);

        // sw with dReady already high, including outside MEM
        instr = 32'h0020A023;
        dReady = 1'b1;
        step("sw_if", IDLE);
        step("sw_id", IDLE);
        step("sw_ex", mk(0, 1, 0, 0, 0, 0, 0, 4'b0010));
        step("sw_mem", mk(0, 1, 0, 0, 0, 0, 1, 4'b0010));
        step("sw_wb", mk(0, 1, 0, 0, 1, 0, 0, 4'b0010));
        dReady = 1'b0;
        exp_ret++;

        // beq taken then not taken
        instr = 32'h00208463;
        Zero = 1'b1;
        step("beq1_if", IDLE);
        step("beq1_id", IDLE);
        step("beq1_ex", mk(0, 0, 0, 0, 0, 0, 0, 4'b0110));
        step("beq1_wb", mk(1, 0, 0, 0, 1, 0, 0, 4'b0110));
        Zero = 1'b0;
        step("beq0_if", IDLE);
        step("beq0_id", IDLE);
        step("beq0_ex", mk(0, 0, 0, 0, 0, 0, 0, 4'b0110));
        step("beq0_wb", mk(0, 0, 0, 0, 1, 0, 0, 4'b0110));
        exp_ret += 2;
        chk("beq_ret", retired, exp_ret);

        run_alu("srai", 32'h4020D193, 1'b1, 4'b1010);
        run_alu("sub",  32'h402081B3, 1'b0, 4'b0110);
        run_alu("addi_neg", 32'hC0008093, 1'b1, 4'b0010);
        run_alu("srl",  32'h0020D1B3, 1'b0, 4'b1000);
        run_alu("sll",  32'h002091B3, 1'b0, 4'b1001);
        run_alu("slti", 32'h0050A193, 1'b1, 4'b0111);
        run_alu("sltu", 32'h0020B1B3, 1'b0, 4'b0010);
        run_alu("xor",  32'h0020C1B3, 1'b0, 4'b0101);
        run_alu("ori",  32'h0050E193, 1'b1, 4'b0001);
        run_alu("and",  32'h0020F1B3, 1'b0, 4'b0000);

        // unsupported opcode
        instr = 32'h0000007F;
        step("ill_if", IDLE);
        step("ill_id", IDLE);
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 3; i++) step("ill_halt", IDLE);
        chk("ill_flag", {31'd0, illegal}, 32'd1);
        chk("ill_ret_frozen", retired, exp_ret);
`else
        step("ill_ex", mk(0, 0, 0, 0, 0, 0, 0, 4'b0010));
        step("ill_wb", mk(0, 0, 0, 0, 1, 0, 0, 4'b0010));
        exp_ret++;
        chk("ill_ret", retired, exp_ret);
        chk("ill_flag", {31'd0, illegal}, 32'd0);
`endif

        // reset during lw MEM wait
        instr = 32'h0000A283;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        step("rlw_if", IDLE);
        step("rlw_id", IDLE);
        step("rlw_ex", mk(0, 1, 0, 0, 0, 0, 0, 4'b0010));
        step("rlw_mem", mk(0, 1, 0, 0, 0, 1, 0, 4'b0010));
        chk("rlw_mem2", {21'd0, outs}, {21'd0, mk(0, 1, 0, 0, 0, 1, 0, 4'b0010)});
        rst = 1'b1;
        #1;
        chk("rst_outs", {21'd0, outs}, {21'd0, IDLE});
        chk("rst_ret", retired, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_ret = 0;
        run_alu("post_rst_add", 32'h002081B3, 1'b0, 4'b0010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
